serial_frame_rx: RTL and testbench

Framed serial receiver: the far end of the team's parallel-in/serial-out link. Samples a single-bit line once per clock, detects a start bit, shifts in `DATA_W` data bits, checks the stop bit and, optionally, a parity bit. Presents each good word on a registered parallel output with a valid/ready handshake. Sits between a PISO-style transmitter on the shared `clk` domain and the consuming parallel logic.

---
 rtl/serial_frame_rx.sv | 139 +++++++++++++
 tb/tb_serial_frame_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, DATA_W data bits, optional even parity, stop bit.
// Optional parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int unsigned DATA_W    = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int unsigned      CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_RECOVER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_RECOVER} state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W:0]   ext;
  logic              word_ok;

  // Concatenate then slice so the shift also works for DATA_W == 1.
  always_comb begin
    ext        = '0;
    shift_next = shreg;
    if (MSB_FIRST) begin
      ext        = {shreg, sin};
      shift_next = ext[DATA_W-1:0];
    end else begin
      ext        = {sin, shreg};
      shift_next = ext[DATA_W:1];
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic par_bad;
  assign word_ok = ~par_bad;
`else
  assign word_ok    = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (ovr_clr)                overrun   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!sin) begin
            state <= S_DATA;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_DATA: begin
          shreg <= shift_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          par_bad <= (^shreg) ^ sin;
          state   <= S_STOP;
        end
`endif
        S_STOP: begin
`ifdef SERIAL_RX_PARITY_EN
          parity_err <= par_bad;
`endif
          if (sin) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            // A load on the draining edge overrides the handshake clear above.
            if (word_ok) begin
              if (!out_valid || out_ready) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            state     <= S_RECOVER;
            frame_err <= 1'b1;
          end
        end
        S_RECOVER: begin
          if (sin) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized bench for serial_frame_rx against a frame-level schedule and holding-register model.
module tb_serial_frame_rx;
  localparam int unsigned DW   = 4;
  localparam bit          MSBF = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sin = 1'b1;
  logic          out_ready = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid, busy, frame_err, parity_err, overrun;

  serial_frame_rx #(.DATA_W(DW), .MSB_FIRST(MSBF)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle schedule: line value, expected busy after the edge, stop event, word.
  bit            sin_q[$];
  bit            busy_q[$];
  int            ev_q[$];    // 0 none, 1 good stop, 2 bad stop
  bit            pe_q[$];
  logic [DW-1:0] w_q[$];
  bit            rdy_q[$];
  bit            clr_q[$];
  int            rmode = 0;  // 0 ready low, 1 ready high, 2 random
  bit            clr_force = 1'b0;

  task automatic add_cycle(input bit s, input bit b, input int ev, input bit pe,
                           input logic [DW-1:0] w);
    sin_q.push_back(s);
    busy_q.push_back(b);
    ev_q.push_back(ev);
    pe_q.push_back(pe);
    w_q.push_back(w);
    rdy_q.push_back(rmode == 0 ? 1'b0 : (rmode == 1 ? 1'b1 : 1'($urandom_range(0, 1))));
    clr_q.push_back(clr_force || (rmode == 2 && $urandom_range(0, 7) == 0));
  endtask

  task automatic add_frame(input logic [DW-1:0] d, input bit stop_ok, input bit par_ok,
                           input int gap, input int extra_low);
    bit pe;
    pe = 1'b0;
    for (int i = 0; i < gap; i++) add_cycle(1'b1, 1'b0, 0, 1'b0, '0);
    add_cycle(1'b0, 1'b1, 0, 1'b0, '0);
    for (int i = 0; i < int'(DW); i++)
      add_cycle(MSBF ? d[DW-1-i] : d[i], 1'b1, 0, 1'b0, '0);
`ifdef SERIAL_RX_PARITY_EN
    pe = ~par_ok;
    add_cycle((^d) ^ pe, 1'b1, 0, 1'b0, '0);
`else
    if (par_ok) pe = 1'b0;
`endif
    if (stop_ok) begin
      add_cycle(1'b1, 1'b0, 1, pe, d);
    end else begin
      add_cycle(1'b0, 1'b1, 2, pe, d);
      for (int i = 0; i < extra_low; i++) add_cycle(1'b0, 1'b1, 0, 1'b0, '0);
      add_cycle(1'b1, 1'b0, 0, 1'b0, '0);
    end
  endtask

  logic          mv, old_mv, movr;
  logic [DW-1:0] md;

  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 sin = 1'b0;
    @(posedge clk);
    #1 sin = 1'b1;
    @(posedge clk);
    #1 sin = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);
    sin = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    rmode = 0;
    add_frame(4'hA, 1'b1, 1'b1, 1, 0);
    rmode = 1;
    add_cycle(1'b1, 1'b0, 0, 1'b0, '0);
    add_frame(4'h3, 1'b1, 1'b1, 0, 0);
    add_frame(4'hC, 1'b1, 1'b1, 0, 0);
    add_cycle(1'b1, 1'b0, 0, 1'b0, '0);
    rmode = 0;
    add_frame(4'h5, 1'b1, 1'b1, 1, 0);
    add_frame(4'h9, 1'b1, 1'b1, 0, 0);
    clr_force = 1'b1;
    add_cycle(1'b1, 1'b0, 0, 1'b0, '0);
    clr_force = 1'b0;
    add_frame(4'h6, 1'b0, 1'b1, 1, 3);
`ifdef SERIAL_RX_PARITY_EN
    rmode = 1;
    add_frame(4'hA, 1'b1, 1'b0, 1, 0);
    add_frame(4'hA, 1'b1, 1'b1, 1, 0);
    add_frame(4'h7, 1'b0, 1'b0, 1, 1);
`endif
    rmode = 2;
    for (int f = 0; f < 60; f++)
      add_frame(DW'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 2), $urandom_range(0, 3));
    add_cycle(1'b1, 1'b0, 0, 1'b0, '0);

    mv   = 1'b0;
    md   = '0;
    movr = 1'b0;
    for (int c = 0; c < sin_q.size(); c++) begin
      sin       = sin_q[c];
      out_ready = rdy_q[c];
      ovr_clr   = clr_q[c];
      @(posedge clk);
      #1;
      old_mv = mv;
      if (mv && rdy_q[c]) mv = 1'b0;
      if (clr_q[c]) movr = 1'b0;
      if (ev_q[c] == 1 && !pe_q[c]) begin
        if (!old_mv || rdy_q[c]) begin
          mv = 1'b1;
          md = w_q[c];
        end else begin
          movr = 1'b1;
        end
      end
      check("valid", out_valid, mv);
      check("data", out_data, md);
      check("busy", busy, busy_q[c]);
      check("frame_err", frame_err, ev_q[c] == 2);
      check("parity_err", parity_err, ev_q[c] != 0 && pe_q[c]);
      check("overrun", overrun, movr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
